// File: rtl/cu_pkg.sv
// Shared types and encodings for the multicycle control unit: state set,
// opcode map, ALU operation codes and trap causes.
package cu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH1,
    FETCH2,
    MEM,
    EXEC,
    JUMP,
    HALT,
    TRAP
  } state_t;

  localparam logic [3:0] OP_LW   = 4'b0000;
  localparam logic [3:0] OP_SW   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0101;
  localparam logic [3:0] OP_AND  = 4'b0110;
  localparam logic [3:0] OP_OR   = 4'b0111;
  localparam logic [3:0] OP_J    = 4'b1000;
  localparam logic [3:0] OP_JCZ  = 4'b1001;
  localparam logic [3:0] OP_JCO  = 4'b1010;
  localparam logic [3:0] OP_HALT = 4'b1011;

  localparam logic [1:0] ALU_SUB = 2'd0;
  localparam logic [1:0] ALU_ADD = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_OR  = 2'd3;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  // The low two opcode bits of a compute instruction pick the ALU operation.
  function automatic logic [1:0] exec_alu_code(input logic [1:0] sel);
    case (sel)
      2'b00:   return ALU_ADD;
      2'b01:   return ALU_SUB;
      2'b10:   return ALU_AND;
      default: return ALU_OR;
    endcase
  endfunction

  // Instruction class chosen at the end of the second fetch word.
  function automatic state_t decode_next(input logic [3:0] op4, input logic upper_nz);
    if (upper_nz) return TRAP;
    case (op4)
      OP_LW, OP_SW:                  return MEM;
      OP_ADD, OP_SUB, OP_AND, OP_OR: return EXEC;
      OP_J, OP_JCZ, OP_JCO:          return JUMP;
      OP_HALT:                       return HALT;
      default:                       return TRAP;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_unit_mem_wait_timer.sv
// Counts cycles spent waiting on memory and flags the last allowed wait cycle.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic increment,
  output logic expired
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  logic [CNT_W-1:0] count_reg, count_next;

  always_comb begin
    count_next = count_reg;
    if (clear) count_next = '0;
    else if (increment) count_next = count_reg + CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) count_reg <= '0;
    else count_reg <= count_next;
  end

  generate
    if (MEM_TIMEOUT == 0) begin : g_no_timeout
      assign expired = 1'b0;
    end else begin : g_timeout
      assign expired = (count_reg == CNT_W'(MEM_TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/multicycle_control_unit.sv
// Sequencer for the single-bus datapath: two-word fetch, then load/store,
// compute, jump, halt or trap, driving every datapath enable and select.
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int OPCODE_W    = 4,
  parameter int ALU_CTRL_W  = 2,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic                  zero_flag,
  input  logic                  overflow_flag,
  input  logic                  mem_ready,
  output logic                  pc_enable,
  output logic                  ir1_enable,
  output logic                  ir2_enable,
  output logic                  alu_out_enable,
  output logic                  pc_select,
  output logic                  adr_select,
  output logic                  reg_select,
  output logic                  wd_select,
  output logic                  operand1_select,
  output logic                  operand2_select,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  mem_read,
  output logic                  mem_enable,
  output logic                  reg_enable,
  output logic                  busy,
  output logic                  halted,
  output logic                  trap,
  output logic [1:0]            trap_cause
);

  generate
    if (ALU_CTRL_W < 2 || OPCODE_W < 4) begin : g_bad_params
      $error("multicycle_control_unit: ALU_CTRL_W must be >= 2 and OPCODE_W >= 4");
    end
  endgenerate

  state_t              state_reg, state_next;
  logic [OPCODE_W-1:0] op_reg, op_next;
  logic [1:0]          trap_cause_reg, trap_cause_next;
  logic [1:0]          alu_code;
  logic                fetch_upper_nz;
  logic                timer_clear, timer_inc, timer_expired;

  assign fetch_upper_nz = (opcode >> 4) != '0;

  // The wait count only runs while an access is outstanding in MEM.
  assign timer_clear = (state_reg != MEM) || mem_ready;
  assign timer_inc   = (state_reg == MEM) && !mem_ready;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (timer_clear),
    .increment(timer_inc),
    .expired  (timer_expired)
  );

  always_comb begin
    state_next      = state_reg;
    op_next         = op_reg;
    trap_cause_next = trap_cause_reg;
    case (state_reg)
      IDLE:   if (start) state_next = FETCH1;
      FETCH1: state_next = FETCH2;
      FETCH2: begin
        op_next    = opcode;
        state_next = decode_next(opcode[3:0], fetch_upper_nz);
        if (state_next == TRAP) trap_cause_next = CAUSE_ILLEGAL;
      end
      MEM: begin
        // A completing access beats the timeout in the same cycle.
        if (mem_ready) begin
          state_next = FETCH1;
        end else if (timer_expired) begin
          state_next      = TRAP;
          trap_cause_next = CAUSE_TIMEOUT;
        end
      end
      EXEC:    state_next = FETCH1;
      JUMP:    state_next = FETCH1;
      HALT:    if (start) state_next = FETCH1;
      default: state_next = TRAP;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      op_reg         <= '0;
      trap_cause_reg <= CAUSE_NONE;
    end else begin
      state_reg      <= state_next;
      op_reg         <= op_next;
      trap_cause_reg <= trap_cause_next;
    end
  end

  always_comb begin
    pc_enable       = 1'b0;
    ir1_enable      = 1'b0;
    ir2_enable      = 1'b0;
    alu_out_enable  = 1'b0;
    pc_select       = 1'b0;
    adr_select      = 1'b0;
    reg_select      = 1'b0;
    wd_select       = 1'b0;
    operand1_select = 1'b0;
    operand2_select = 1'b0;
    alu_code        = ALU_SUB;
    mem_read        = 1'b0;
    mem_enable      = 1'b0;
    reg_enable      = 1'b0;
    busy            = 1'b0;
    halted          = 1'b0;
    trap            = 1'b0;
    case (state_reg)
      FETCH1: begin
        mem_read   = 1'b1;
        ir1_enable = 1'b1;
        pc_enable  = 1'b1;
        alu_code   = ALU_ADD;
        busy       = 1'b1;
      end
      FETCH2: begin
        mem_read   = 1'b1;
        ir2_enable = 1'b1;
        pc_enable  = 1'b1;
        busy       = 1'b1;
      end
      MEM: begin
        adr_select = 1'b1;
        reg_select = 1'b1;
        wd_select  = 1'b1;
        busy       = 1'b1;
        if (op_reg == OPCODE_W'(OP_LW)) begin
          mem_read   = 1'b1;
          reg_enable = mem_ready;
        end else begin
          mem_enable = 1'b1;
        end
      end
      EXEC: begin
        operand1_select = 1'b1;
        operand2_select = 1'b1;
        alu_out_enable  = 1'b1;
        reg_enable      = 1'b1;
        alu_code        = exec_alu_code(op_reg[1:0]);
        busy            = 1'b1;
      end
      JUMP: begin
        pc_select = 1'b1;
        busy      = 1'b1;
        // Branch condition is evaluated on the live flags this cycle.
        pc_enable = (op_reg == OPCODE_W'(OP_J))
                 || ((op_reg == OPCODE_W'(OP_JCZ)) && zero_flag)
                 || ((op_reg == OPCODE_W'(OP_JCO)) && overflow_flag);
      end
      HALT:    halted = 1'b1;
      TRAP:    trap = 1'b1;
      default: ;
    endcase
  end

  assign alu_control = ALU_CTRL_W'(alu_code);
  assign trap_cause  = trap_cause_reg;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomised instruction-level bench: each instruction's per-cycle outputs are
// predicted from the instruction rules and compared on every falling edge.
module tb_multicycle_control_unit;

  localparam int OPCODE_W    = 4;
  localparam int ALU_CTRL_W  = 2;
  localparam int MEM_TIMEOUT = 15;

  localparam int K_MEM = 0, K_EXEC = 1, K_JUMP = 2, K_HALT = 3, K_ILL = 4;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic [OPCODE_W-1:0] opcode = '0;
  logic zero_flag = 1'b0, overflow_flag = 1'b0, mem_ready = 1'b0;
  logic pc_enable, ir1_enable, ir2_enable, alu_out_enable;
  logic pc_select, adr_select, reg_select, wd_select, operand1_select, operand2_select;
  logic [ALU_CTRL_W-1:0] alu_control;
  logic mem_read, mem_enable, reg_enable, busy, halted, trap;
  logic [1:0] trap_cause;

  multicycle_control_unit #(
    .OPCODE_W(OPCODE_W), .ALU_CTRL_W(ALU_CTRL_W), .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .opcode(opcode),
    .zero_flag(zero_flag), .overflow_flag(overflow_flag), .mem_ready(mem_ready),
    .pc_enable(pc_enable), .ir1_enable(ir1_enable), .ir2_enable(ir2_enable),
    .alu_out_enable(alu_out_enable), .pc_select(pc_select), .adr_select(adr_select),
    .reg_select(reg_select), .wd_select(wd_select), .operand1_select(operand1_select),
    .operand2_select(operand2_select), .alu_control(alu_control), .mem_read(mem_read),
    .mem_enable(mem_enable), .reg_enable(reg_enable), .busy(busy), .halted(halted),
    .trap(trap), .trap_cause(trap_cause)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic pc_en, ir1_en, ir2_en, alu_out_en, pc_sel, adr_sel, reg_sel, wd_sel, op1_sel, op2_sel;
    logic [1:0] alu;
    logic mem_read, mem_enable, reg_en, busy, halted, trap;
    logic [1:0] cause;
  } outs_t;

  outs_t exp_q[$];
  outs_t exp_v, act_v, last_obs;
  int n_cmp = 0, n_bad = 0;
  int n_strobe = 0, n_regen = 0;
  bit trapped;

  function automatic outs_t dut_outs();
    outs_t o;
    o.pc_en = pc_enable;         o.ir1_en = ir1_enable;     o.ir2_en = ir2_enable;
    o.alu_out_en = alu_out_enable; o.pc_sel = pc_select;    o.adr_sel = adr_select;
    o.reg_sel = reg_select;      o.wd_sel = wd_select;      o.op1_sel = operand1_select;
    o.op2_sel = operand2_select; o.alu = alu_control[1:0];  o.mem_read = mem_read;
    o.mem_enable = mem_enable;   o.reg_en = reg_enable;     o.busy = busy;
    o.halted = halted;           o.trap = trap;             o.cause = trap_cause;
    return o;
  endfunction

  // Expected outputs per instruction phase, straight from the instruction rules.
  function automatic outs_t e_fetch1();
    outs_t e = '0;
    e.mem_read = 1; e.ir1_en = 1; e.pc_en = 1; e.alu = 2'd1; e.busy = 1;
    return e;
  endfunction

  function automatic outs_t e_fetch2();
    outs_t e = '0;
    e.mem_read = 1; e.ir2_en = 1; e.pc_en = 1; e.busy = 1;
    return e;
  endfunction

  function automatic outs_t e_mem(input bit is_load, input bit ready);
    outs_t e = '0;
    e.adr_sel = 1; e.reg_sel = 1; e.wd_sel = 1; e.busy = 1;
    if (is_load) begin e.mem_read = 1; e.reg_en = ready; end
    else e.mem_enable = 1;
    return e;
  endfunction

  function automatic outs_t e_exec(input logic [3:0] op);
    outs_t e = '0;
    logic [1:0] amap [4];
    amap = '{2'd1, 2'd0, 2'd2, 2'd3};
    e.op1_sel = 1; e.op2_sel = 1; e.alu_out_en = 1; e.reg_en = 1; e.busy = 1;
    e.alu = amap[op[1:0]];
    return e;
  endfunction

  function automatic outs_t e_jump(input logic [3:0] op, input logic z, input logic v);
    outs_t e = '0;
    e.pc_sel = 1; e.busy = 1;
    e.pc_en = (op == 4'b1000) || (op == 4'b1001 && z) || (op == 4'b1010 && v);
    return e;
  endfunction

  function automatic outs_t e_halt();
    outs_t e = '0;
    e.halted = 1;
    return e;
  endfunction

  function automatic outs_t e_trap(input logic [1:0] c);
    outs_t e = '0;
    e.trap = 1; e.cause = c;
    return e;
  endfunction

  function automatic int op_kind(input logic [3:0] op);
    if (op[3:2] == 2'b11) return K_ILL;
    if (op == 4'b1011) return K_HALT;
    if (op[3:2] == 2'b00) return (op <= 4'b0001) ? K_MEM : K_ILL;
    if (op[3:2] == 2'b01) return K_EXEC;
    return K_JUMP;
  endfunction

  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      act_v = dut_outs();
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL cycle_outputs @%0t: got %h, expected %h", $time, act_v, exp_v);
      end
    end
  end

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  task automatic rand_inputs();
    start         = 1'($urandom_range(0, 1));
    opcode        = OPCODE_W'($urandom);
    zero_flag     = 1'($urandom_range(0, 1));
    overflow_flag = 1'($urandom_range(0, 1));
    mem_ready     = 1'($urandom_range(0, 1));
  endtask

  // One clock cycle: queue the prediction, observe mid-cycle, advance.
  task automatic cyc(input outs_t e);
    exp_q.push_back(e);
    #1;
    last_obs = dut_outs();
    if (last_obs.adr_sel && (last_obs.mem_read || last_obs.mem_enable)) n_strobe++;
    if (last_obs.adr_sel && last_obs.reg_en) n_regen++;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin rand_inputs(); start = 1'b0; cyc('0); end
  endtask

  task automatic kick();
    rand_inputs(); start = 1'b1; cyc('0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    lit("reset_async_outputs", 32'(dut_outs()), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic run_instr(input logic [3:0] op, input int rdy_at, input int flags, output bit tr);
    int kind;
    int hold;
    logic [1:0] cause;
    tr = 0; cause = 2'd0; n_strobe = 0; n_regen = 0;
    rand_inputs(); cyc(e_fetch1());
    rand_inputs(); opcode = OPCODE_W'(op); cyc(e_fetch2());
    kind = op_kind(op);
    case (kind)
      K_EXEC: begin rand_inputs(); cyc(e_exec(op)); end
      K_JUMP: begin
        rand_inputs();
        if (flags >= 0) begin zero_flag = flags[0]; overflow_flag = flags[1]; end
        cyc(e_jump(op, zero_flag, overflow_flag));
      end
      K_MEM: begin
        for (int k = 0; k < MEM_TIMEOUT; k++) begin
          rand_inputs();
          mem_ready = (k == rdy_at);
          cyc(e_mem(op == 4'b0000, mem_ready));
          if (k == rdy_at) break;
          if (k == MEM_TIMEOUT - 1) begin tr = 1; cause = 2'd2; end
        end
      end
      K_HALT: begin
        hold = $urandom_range(0, 3);
        repeat (hold) begin rand_inputs(); start = 1'b0; cyc(e_halt()); end
        rand_inputs(); start = 1'b1; cyc(e_halt());
      end
      default: begin tr = 1; cause = 2'd1; end
    endcase
    if (tr) begin
      repeat (3) begin rand_inputs(); start = 1'b1; cyc(e_trap(cause)); end
    end
    $display("instr op=%b ready_at=%0d trapped=%0d", op, rdy_at, tr);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    lit("reset_outputs", 32'(dut_outs()), 32'd0);
    reset_n = 1'b1;
    idle(2);
    kick();

    run_instr(4'b0100, 0, -1, trapped);
    lit("exec_alu_control", 32'(last_obs.alu), 32'd1);
    lit("exec_reg_enable", 32'(last_obs.reg_en), 32'd1);
    lit("exec_alu_out_enable", 32'(last_obs.alu_out_en), 32'd1);

    run_instr(4'b0000, 3, -1, trapped);
    lit("lw_read_cycles", 32'(n_strobe), 32'd4);
    lit("lw_reg_enable_cycles", 32'(n_regen), 32'd1);

    run_instr(4'b0000, MEM_TIMEOUT - 1, -1, trapped);
    lit("lw_ready_in_timeout_cycle", 32'(trapped), 32'd0);
    lit("lw_ready_in_timeout_read_cycles", 32'(n_strobe), 32'd15);

    run_instr(4'b1001, 0, 0, trapped);
    lit("jcz_not_taken_pc_select", 32'(last_obs.pc_sel), 32'd1);
    lit("jcz_not_taken_pc_enable", 32'(last_obs.pc_en), 32'd0);
    run_instr(4'b1001, 0, 1, trapped);
    lit("jcz_taken_pc_enable", 32'(last_obs.pc_en), 32'd1);

    run_instr(4'b1011, 0, -1, trapped);
    lit("halt_halted", 32'(last_obs.halted), 32'd1);

    run_instr(4'b0001, 99, -1, trapped);
    lit("sw_timeout_write_cycles", 32'(n_strobe), 32'd15);
    lit("sw_timeout_trap", 32'(last_obs.trap), 32'd1);
    lit("sw_timeout_cause", 32'(last_obs.cause), 32'd2);
    do_reset();
    idle(1);
    kick();

    run_instr(4'b1100, 0, -1, trapped);
    lit("illegal_cause", 32'(last_obs.cause), 32'd1);
    do_reset();
    idle(1);

    // Reset arriving in the middle of a pending load.
    kick();
    rand_inputs(); cyc(e_fetch1());
    rand_inputs(); opcode = '0; cyc(e_fetch2());
    repeat (2) begin rand_inputs(); mem_ready = 1'b0; cyc(e_mem(1, 0)); end
    rand_inputs(); mem_ready = 1'b0;
    exp_q.push_back(e_mem(1, 0));
    @(negedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    lit("mid_mem_reset_mem_read", 32'(mem_read), 32'd0);
    lit("mid_mem_reset_busy", 32'(busy), 32'd0);
    lit("mid_mem_reset_all_outputs", 32'(dut_outs()), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    idle(2);
    kick();

    for (int i = 0; i < 150; i++) begin
      run_instr(4'($urandom_range(0, 15)), $urandom_range(0, 17), -1, trapped);
      if (trapped) begin
        do_reset();
        idle(1);
        kick();
      end
    end

    @(posedge clock);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Parametrised successor to the two-word-fetch multicycle controller. It sequences fetch, decode, load/store, compute, jump, halt and trap for the single-bus datapath. Additions over the previous generation: async reset, start/resume handshake, variable-latency memory with timeout, four ALU operations, and illegal-opcode trapping. It sits between the instruction registers/flags and every datapath enable and mux select.

Parameters:
OPCODE_W, 4, opcode width; must be >= 4, and bits above [3] must be zero for a legal opcode.
ALU_CTRL_W, 2, width of alu_control.
MEM_TIMEOUT, 15, maximum MEM wait cycles before trapping; 0 disables the timeout.

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  begin execution from IDLE, or resume from HALT
opcode  in  OPCODE_W  opcode field from IR1
zero_flag  in  1  ALU zero flag
overflow_flag  in  1  ALU overflow flag
mem_ready  in  1  memory access complete; sampled only in MEM
pc_enable, ir1_enable, ir2_enable, alu_out_enable  out  1 each  register enables
pc_select, adr_select, reg_select, wd_select, operand1_select, operand2_select  out  1 each  mux selects
alu_control  out  ALU_CTRL_W  ALU operation code
mem_read  out  1  memory read strobe
mem_enable  out  1  memory write strobe
reg_enable  out  1  register-file write enable
busy  out  1  high in FETCH1/FETCH2/MEM/EXEC/JUMP
halted  out  1  high in HALT
trap  out  1  high in TRAP
trap_cause  out  2  0 none, 1 illegal opcode, 2 memory timeout

Behaviour:
- State register, op_q (OPCODE_W), wait counter and trap_cause are clocked.
- All other outputs are decoded combinationally from state, op_q and flags (Moore, plus flags in JUMP).
- reset_n low: asynchronously forces state IDLE, op_q 0, counter 0, trap_cause 0. Every output is 0 while in IDLE.
- Any output not listed for a state is 0.
- IDLE: no outputs asserted. start=1 -> FETCH1.
- FETCH1: mem_read=1, ir1_enable=1, pc_enable=1, alu_control=ALU_ADD. Next -> FETCH2.
- FETCH2: mem_read=1, ir2_enable=1, pc_enable=1. op_q <= opcode. Next state is decoded from the incoming opcode:
  - upper bits nonzero or [3:2]=11 -> TRAP, cause 1
  - 1011 -> HALT
  - 00xx -> MEM (0000 lw, 0001 sw; 0010/0011 are illegal -> TRAP, cause 1)
  - 01xx -> EXEC
  - 10xx -> JUMP
- MEM: adr_select=1, reg_select=1, wd_select=1.
  - lw: mem_read=1 held; reg_enable=1 only in the cycle mem_ready=1.
  - sw: mem_enable=1 held until mem_ready=1.
  - mem_ready=1 -> FETCH1, counter cleared.
  - Otherwise the counter increments. If the counter reaches MEM_TIMEOUT-1 with mem_ready still 0 -> TRAP, cause 2.
  - mem_ready=1 in the timeout cycle wins: the access completes normally.
- EXEC: operand1_select=1, operand2_select=1, alu_out_enable=1, reg_enable=1, wd_select=0. alu_control is set from op_q[1:0]: 00 ALU_ADD, 01 ALU_SUB, 10 ALU_AND, 11 ALU_OR. Next -> FETCH1.
- JUMP: pc_select=1. pc_enable is the combinational "taken" term:
  - 1000: always taken
  - 1001: taken when zero_flag=1
  - 1010: taken when overflow_flag=1
  Flags are sampled in this cycle. Next -> FETCH1.
- HALT: halted=1. start=1 -> FETCH1 (resume at current PC).
- TRAP: trap=1, trap_cause held. Exit only by reset; start is ignored.
- start is ignored outside IDLE/HALT. mem_ready is ignored outside MEM.
- Reset asserted mid-MEM drops all strobes immediately (asynchronously).
- Latency:
  - EXEC and JUMP instructions: 3 cycles.
  - lw/sw: 3 + wait cycles.
  - Halt: 2 cycles to reach HALT.
- Encoding widths: alu_control codes are zero-extended to ALU_CTRL_W. ALU_CTRL_W < 2 is illegal and is rejected at elaboration.

Decomposition:
- Package cu_pkg holds:
  - state enum: IDLE, FETCH1, FETCH2, MEM, EXEC, JUMP, HALT, TRAP
  - opcode constants: OP_LW, OP_SW, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_J, OP_JCZ, OP_JCO, OP_HALT
  - ALU codes: ALU_SUB=0, ALU_ADD=1, ALU_AND=2, ALU_OR=3
  - trap cause codes
- One sub-module, mem_wait_timer: clear/increment counter with a timeout comparison, parametrised by MEM_TIMEOUT.

Test Plan:
- Reset, start, opcode 0100 at FETCH2 -> FETCH1, FETCH2, EXEC. EXEC shows alu_control=1, reg_enable=1, alu_out_enable=1; back to FETCH1 on cycle 4.
- Opcode 0000 with mem_ready delayed 3 cycles -> mem_read high for 4 MEM cycles; reg_enable high only in the 4th; then FETCH1.
- Opcode 0001 with mem_ready never asserted (MEM_TIMEOUT=15) -> mem_enable high for 15 MEM cycles, then trap=1, trap_cause=2, outputs 0. start is ignored.
- Opcode 1001 with zero_flag=0, then again with zero_flag=1 -> JUMP has pc_select=1 both times; pc_enable=0 the first time, 1 the second.
- Opcode 1011, then start pulse -> halted=1 until start, then FETCH1. Opcode 1100 -> TRAP, trap_cause=1.
- reset_n dropped mid-MEM -> all strobes 0 in the same cycle; state IDLE; busy=0.
